// File: rtl/lc3_trace_pkg.sv
// -----------------------------------------------------------------------------
// lc3_trace_pkg
// Shared definitions for the lc3 trace buffer: the capture FSM state encoding
// and the width of the exported state field.
// -----------------------------------------------------------------------------
package lc3_trace_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/lc3_trace_ram.sv
// -----------------------------------------------------------------------------
// lc3_trace_ram
// DEPTH x DATA_W trace storage with one write port and a registered read port
// (read data appears the cycle after re). Storage is not reset; only the read
// register is cleared by reset so the popped-data output starts at zero.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset (read register only)
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   re     - read enable; rdata updates next cycle, holds otherwise
//   raddr  - read address
//   rdata  - registered read data
// -----------------------------------------------------------------------------
module lc3_trace_ram #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/lc3_trace_buffer.sv
// -----------------------------------------------------------------------------
// lc3_trace_buffer
// Logic-analyser style trace capture. After arm, samples are stored into a
// circular window of PRE_TRIG entries; a trigger switches to post-trigger
// capture of DEPTH-PRE_TRIG entries (trigger sample included), after which the
// buffer freezes in DONE and can be drained oldest-first with rd_en.
//
// Optional feature (macro LC3_TRACE_CHANGE_ONLY_EN): while ARMED or POST, a
// sample equal to the last stored entry is dropped. A trigger sample is always
// stored. Without the macro every sample_en stores.
//
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-low reset
//   arm       - start / restart a capture
//   sample_en - ch_data is valid this cycle
//   ch_data   - NUM_CH channels of CH_W bits, channel 0 in LSBs
//   trig_in   - trigger event
//   rd_en     - pop oldest entry (honoured only in DONE with count > 0)
//   rd_data   - popped entry, valid the cycle after rd_en
//   rd_valid  - one-cycle pulse per accepted pop
//   state     - FSM state (IDLE/ARMED/POST/DONE)
//   count     - entries held
//   done      - capture complete, buffer frozen
// -----------------------------------------------------------------------------
module lc3_trace_buffer
    import lc3_trace_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CH_W     = 16,
    parameter int DEPTH    = 16,
    parameter int PRE_TRIG = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     sample_en,
    input  logic [NUM_CH*CH_W-1:0]   ch_data,
    input  logic                     trig_in,
    input  logic                     rd_en,
    output logic [NUM_CH*CH_W-1:0]   rd_data,
    output logic                     rd_valid,
    output logic [STATE_W-1:0]       state,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     done
);

    localparam int DW = NUM_CH * CH_W;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] PRE_CNT   = CW'(PRE_TRIG);
    localparam logic [CW-1:0] POST_LAST = CW'(DEPTH - PRE_TRIG - 1);

    state_t          cur_state, nxt_state;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   post_cnt;
    logic            restart, store, is_post, pop, keep;

`ifdef LC3_TRACE_CHANGE_ONLY_EN
    logic            have_last;
    logic [DW-1:0]   last_data;

    assign keep = !(have_last && (ch_data == last_data));
`else
    assign keep = 1'b1;
`endif

    // Next-state and per-cycle action decode. arm has priority over every
    // other input in all states, which is what makes restart atomic.
    always_comb begin
        nxt_state = cur_state;
        restart   = 1'b0;
        store     = 1'b0;
        is_post   = 1'b0;
        pop       = 1'b0;
        case (cur_state)
            IDLE: begin
                if (arm) begin
                    restart   = 1'b1;
                    nxt_state = ARMED;
                end
            end
            ARMED: begin
                if (arm) begin
                    restart   = 1'b1;
                    nxt_state = ARMED;
                end else if (trig_in) begin
                    nxt_state = POST;
                    if (sample_en) begin
                        store   = 1'b1;
                        is_post = 1'b1;
                        // post_cnt is zero here; covers a quota of one entry
                        if (post_cnt == POST_LAST) nxt_state = DONE;
                    end
                end else if (sample_en && keep) begin
                    store = 1'b1;
                end
            end
            POST: begin
                if (arm) begin
                    restart   = 1'b1;
                    nxt_state = ARMED;
                end else if (sample_en && keep) begin
                    store   = 1'b1;
                    is_post = 1'b1;
                    if (post_cnt == POST_LAST) nxt_state = DONE;
                end
            end
            DONE: begin
                if (arm) begin
                    restart   = 1'b1;
                    nxt_state = ARMED;
                end else if (rd_en && (count != '0)) begin
                    pop = 1'b1;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            rd_valid  <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            rd_valid  <= pop;
            if (restart) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                post_cnt <= '0;
            end else if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
                // A full pre-trigger window slides: the oldest entry is
                // overwritten, so the read pointer follows the write pointer.
                if (!is_post && (count == PRE_CNT)) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
                if (is_post) begin
                    post_cnt <= post_cnt + 1'b1;
                end
            end else if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - 1'b1;
            end
        end
    end

`ifdef LC3_TRACE_CHANGE_ONLY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            have_last <= 1'b0;
        end else if (restart) begin
            have_last <= 1'b0;
        end else if (store) begin
            have_last <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            last_data <= ch_data;
        end
    end
`endif

    lc3_trace_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (store),
        .waddr (wr_ptr),
        .wdata (ch_data),
        .re    (pop),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign state = cur_state;
    assign done  = (cur_state == DONE);

endmodule

// File: tb/tb_lc3_trace_buffer.sv
module tb_lc3_trace_buffer;

    localparam int NUM_CH   = 4;
    localparam int CH_W     = 16;
    localparam int DEPTH    = 8;
    localparam int PRE_TRIG = 3;
    localparam int DW       = NUM_CH * CH_W;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          arm = 1'b0;
    logic          sample_en = 1'b0;
    logic [DW-1:0] ch_data = '0;
    logic          trig_in = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [1:0]    state;
    logic [3:0]    count;
    logic          done;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    lc3_trace_buffer #(
        .NUM_CH   (NUM_CH),
        .CH_W     (CH_W),
        .DEPTH    (DEPTH),
        .PRE_TRIG (PRE_TRIG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm),
        .sample_en (sample_en),
        .ch_data   (ch_data),
        .trig_in   (trig_in),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .state     (state),
        .count     (count),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] smp(input int n);
        logic [15:0] v;
        v = 16'(n);
        return {v + 16'h3000, v + 16'h2000, v + 16'h1000, v};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; outputs are stable 1 time unit after the edge.
    task automatic cyc(input logic a, input logic s, input logic t, input logic r,
                       input logic [DW-1:0] d);
        arm = a; sample_en = s; trig_in = t; rd_en = r; ch_data = d;
        @(posedge clk);
        #1;
        arm = 1'b0; sample_en = 1'b0; trig_in = 1'b0; rd_en = 1'b0;
    endtask

    task automatic pop_expect(input logic [DW-1:0] d);
        exp_q.push_back(d);
        cyc(0, 0, 0, 1, '0);
        check("rd_valid_latency", rd_valid, 1);
    endtask

    // Monitor: every rd_valid pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (rd_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rd_valid: got data %0h expected no pop", rd_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    bad++;
                    $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_count", count, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // IDLE ignores everything but arm
        cyc(0, 1, 1, 1, smp(99));
        check("idle_ignore_state", state, 0);
        check("idle_ignore_count", count, 0);

        // Full capture: trigger on sample 7, window 4..11
        cyc(1, 0, 0, 0, '0);
        check("arm_state", state, 1);
        check("arm_count", count, 0);
        for (int i = 1; i <= 6; i++) begin
            cyc(0, 1, 0, 0, smp(i));
            if (i == 3) check("pre_fill_count", count, 3);
        end
        check("pre_sat_count", count, 3);
        check("rd_in_armed_state", state, 1);
        cyc(0, 1, 1, 0, smp(7));
        check("trig_state", state, 2);
        check("trig_count", count, 4);
        for (int i = 8; i <= 10; i++) cyc(0, 1, 0, 0, smp(i));
        check("post_state", state, 2);
        check("post_count", count, 7);
        cyc(0, 1, 0, 0, smp(11));
        check("done_state", state, 3);
        check("done_flag", done, 1);
        check("done_count", count, 8);
        cyc(0, 1, 1, 0, smp(12));
        check("done_frozen_count", count, 8);
        for (int k = 4; k <= 11; k++) pop_expect(smp(k));
        check("drained_count", count, 0);
        cyc(0, 0, 0, 1, '0);
        check("empty_pop_rd_valid", rd_valid, 0);
        check("empty_pop_count", count, 0);

        // Early trigger on sample 2: one pre entry, five post
        cyc(1, 0, 0, 0, '0);
        cyc(0, 1, 0, 0, smp(1));
        cyc(0, 1, 1, 0, smp(2));
        check("early_trig_count", count, 2);
        for (int i = 3; i <= 5; i++) cyc(0, 1, 0, 0, smp(i));
        check("early_not_done", state, 2);
        cyc(0, 1, 0, 0, smp(6));
        check("early_done_state", state, 3);
        check("early_done_count", count, 6);
        for (int k = 1; k <= 6; k++) pop_expect(smp(k));
        cyc(0, 0, 0, 1, '0);
        check("early_7th_pop_valid", rd_valid, 0);

        // Re-arm from DONE with simultaneous rd_en
        cyc(1, 0, 0, 0, '0);
        for (int i = 1; i <= 3; i++) cyc(0, 1, 0, 0, smp(20 + i));
        cyc(0, 1, 1, 0, smp(24));
        for (int i = 5; i <= 8; i++) cyc(0, 1, 0, 0, smp(20 + i));
        check("full_count", count, 8);
        cyc(1, 0, 0, 1, '0);
        check("rearm_rd_valid", rd_valid, 0);
        check("rearm_state", state, 1);
        check("rearm_count", count, 0);
        check("rearm_done", done, 0);

        // Async reset mid-POST
        for (int i = 1; i <= 3; i++) cyc(0, 1, 0, 0, smp(30 + i));
        cyc(0, 1, 1, 0, smp(34));
        cyc(0, 1, 0, 0, smp(35));
        check("pre_reset_count", count, 5);
        check("pre_reset_state", state, 2);
        reset = 1'b0;
        #1;
        check("async_rst_state", state, 0);
        check("async_rst_count", count, 0);
        check("async_rst_done", done, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(0, 1, 1, 0, smp(36));
        check("post_rst_trig_state", state, 0);
        check("post_rst_trig_count", count, 0);

        // Trigger without sample, then restart in POST
        cyc(1, 0, 0, 0, '0);
        cyc(0, 0, 1, 0, '0);
        check("bare_trig_state", state, 2);
        check("bare_trig_count", count, 0);
        cyc(0, 1, 0, 0, smp(40));
        cyc(1, 1, 0, 0, smp(41));
        check("restart_post_state", state, 1);
        check("restart_post_count", count, 0);

`ifdef LC3_TRACE_CHANGE_ONLY_EN
        // Change-only: A,A,B,B,C(trig) stores A,B,C
        cyc(0, 1, 0, 0, smp(50));
        cyc(0, 1, 0, 0, smp(50));
        cyc(0, 1, 0, 0, smp(51));
        cyc(0, 1, 0, 0, smp(51));
        check("chg_pre_count", count, 2);
        cyc(0, 1, 1, 0, smp(52));
        check("chg_trig_count", count, 3);
        cyc(0, 1, 0, 0, smp(52));
        check("chg_post_dup_count", count, 3);
        for (int i = 53; i <= 56; i++) cyc(0, 1, 0, 0, smp(i));
        check("chg_done_state", state, 3);
        check("chg_done_count", count, 7);
        for (int k = 50; k <= 56; k++) pop_expect(smp(k));
`else
        // Duplicates are stored when change-only is disabled
        cyc(0, 1, 0, 0, smp(50));
        cyc(0, 1, 0, 0, smp(50));
        check("dup_count", count, 2);
        cyc(0, 1, 1, 0, smp(50));
        check("dup_trig_count", count, 3);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
